// File: rtl/id_stage.sv
// id_stage: decode stage of the five-stage MIPS pipeline.
// Decodes addu/subu/ori/lui/lw/sw/beq/jal/jr. It owns the 32x32 register file,
// resolves branches and jumps in D, forwards ALU results from M, detects
// read-after-write hazards, and registers the decoded fields into D/E.
// Optional macro ID_WB_BYPASS_EN: when it is defined, register reads see a W-stage write
// in the same cycle (write-through). When it is undefined, a W-stage
// dependency stalls for one cycle instead.
module id_stage #(
    parameter logic [31:0] RESET_PC = 32'h00003000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] D_instruc,
    input  logic [31:0] D_PC,
    input  logic [31:0] F_PC,
    input  logic [4:0]  E_waddr,
    input  logic        E_wen,
    input  logic        E_is_load,
    input  logic [4:0]  M_waddr,
    input  logic        M_wen,
    input  logic        M_is_load,
    input  logic [31:0] M_wdata,
    input  logic        W_we,
    input  logic [4:0]  W_waddr,
    input  logic [31:0] W_wdata,
    output logic [31:0] F_NPC,
    output logic        stall,
    output logic [31:0] DE_instruc,
    output logic [31:0] DE_PC,
    output logic [31:0] DE_rs_val,
    output logic [31:0] DE_rt_val,
    output logic [31:0] DE_imm32,
    output logic [4:0]  DE_waddr,
    output logic        DE_wen,
    output logic        DE_is_load
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm16;
    logic [31:0] imm_sext;

    assign op       = D_instruc[31:26];
    assign rs       = D_instruc[25:21];
    assign rt       = D_instruc[20:16];
    assign rd       = D_instruc[15:11];
    assign imm16    = D_instruc[15:0];
    assign funct    = D_instruc[5:0];
    assign imm_sext = {{16{imm16[15]}}, imm16};

    logic is_addu, is_subu, is_ori, is_lui, is_lw, is_sw, is_beq, is_jal, is_jr;
    assign is_addu = (op == OP_RTYPE) && (funct == FN_ADDU);
    assign is_subu = (op == OP_RTYPE) && (funct == FN_SUBU);
    assign is_jr   = (op == OP_RTYPE) && (funct == FN_JR);
    assign is_ori  = (op == OP_ORI);
    assign is_lui  = (op == OP_LUI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_jal  = (op == OP_JAL);

    // Operand use classes. Early operands are consumed in D by branch resolution.
    logic early_rs, early_rt, use_rs, use_rt;
    assign early_rs = is_beq | is_jr;
    assign early_rt = is_beq;
    assign use_rs   = early_rs | is_addu | is_subu | is_ori | is_lw | is_sw;
    assign use_rt   = early_rt | is_addu | is_subu | is_sw;

    logic [4:0]  waddr_dec;
    logic [31:0] imm_dec;
    logic        wen_dec;

    // Destination register and immediate/link value of the instruction in D
    always_comb begin
        waddr_dec = 5'd0;
        imm_dec   = 32'd0;
        if (is_addu || is_subu)             waddr_dec = rd;
        else if (is_ori || is_lui || is_lw) waddr_dec = rt;
        else if (is_jal)                    waddr_dec = 5'd31;
        if (is_ori)                         imm_dec = {16'd0, imm16};
        else if (is_lw || is_sw || is_beq)  imm_dec = imm_sext;
        else if (is_lui)                    imm_dec = {imm16, 16'd0};
        else if (is_jal)                    imm_dec = D_PC + 32'd8;
    end
    assign wen_dec = (waddr_dec != 5'd0);

    logic [31:0] rf_q [32];

    // Register file: a synchronous clear, then writes to $0 are dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
        end else if (W_we && (W_waddr != 5'd0)) begin
            rf_q[W_waddr] <= W_wdata;
        end
    end

    logic [31:0] rs_rf, rt_rf, rs_val, rt_val;

    // Raw register-file read, optionally with W-stage write-through
    always_comb begin
        rs_rf = rf_q[rs];
        rt_rf = rf_q[rt];
`ifdef ID_WB_BYPASS_EN
        if (W_we && (W_waddr == rs)) rs_rf = W_wdata;
        if (W_we && (W_waddr == rt)) rt_rf = W_wdata;
`endif
    end

    // Operand selection: $0, then the M-stage ALU forward, then the register file
    always_comb begin
        if (rs == 5'd0)                                      rs_val = 32'd0;
        else if (M_wen && !M_is_load && (M_waddr == rs))     rs_val = M_wdata;
        else                                                 rs_val = rs_rf;
        if (rt == 5'd0)                                      rt_val = 32'd0;
        else if (M_wen && !M_is_load && (M_waddr == rt))     rt_val = M_wdata;
        else                                                 rt_val = rt_rf;
    end

    function automatic logic hit(input logic used, input logic [4:0] a, input logic [4:0] w);
        return used && (a != 5'd0) && (a == w);
    endfunction

    logic stall_c;

    // RAW hazard detection: values that are not yet available when D needs them
    always_comb begin
        stall_c = 1'b0;
        if (E_wen && (hit(early_rs, rs, E_waddr) || hit(early_rt, rt, E_waddr)))
            stall_c = 1'b1;
        if (M_wen && M_is_load && (hit(early_rs, rs, M_waddr) || hit(early_rt, rt, M_waddr)))
            stall_c = 1'b1;
        if (E_wen && E_is_load && (hit(use_rs, rs, E_waddr) || hit(use_rt, rt, E_waddr)))
            stall_c = 1'b1;
`ifndef ID_WB_BYPASS_EN
        if (W_we && (hit(use_rs, rs, W_waddr) || hit(use_rt, rt, W_waddr)))
            stall_c = 1'b1;
`endif
    end
    assign stall = stall_c;

    // Next fetch PC. The delay slot at F_PC is already in flight.
    always_comb begin
        F_NPC = F_PC + 32'd4;
        if (is_beq && (rs_val == rt_val) && !stall_c)
            F_NPC = D_PC + 32'd4 + {imm_sext[29:0], 2'b00};
        else if (is_jal)
            F_NPC = {D_PC[31:28], D_instruc[25:0], 2'b00};
        else if (is_jr && !stall_c)
            F_NPC = rs_val;
    end

    logic [31:0] de_instruc_q, de_pc_q, de_rs_q, de_rt_q, de_imm_q;
    logic [4:0]  de_waddr_q;
    logic        de_wen_q, de_is_load_q;

    // D/E register: a bubble on reset or stall, otherwise the decoded instruction
    always_ff @(posedge clk) begin
        if (reset || stall_c) begin
            de_instruc_q <= 32'd0;
            de_pc_q      <= RESET_PC;
            de_rs_q      <= 32'd0;
            de_rt_q      <= 32'd0;
            de_imm_q     <= 32'd0;
            de_waddr_q   <= 5'd0;
            de_wen_q     <= 1'b0;
            de_is_load_q <= 1'b0;
        end else begin
            de_instruc_q <= D_instruc;
            de_pc_q      <= D_PC;
            de_rs_q      <= rs_val;
            de_rt_q      <= rt_val;
            de_imm_q     <= imm_dec;
            de_waddr_q   <= waddr_dec;
            de_wen_q     <= wen_dec;
            de_is_load_q <= is_lw;
        end
    end

    assign DE_instruc = de_instruc_q;
    assign DE_PC      = de_pc_q;
    assign DE_rs_val  = de_rs_q;
    assign DE_rt_val  = de_rt_q;
    assign DE_imm32   = de_imm_q;
    assign DE_waddr   = de_waddr_q;
    assign DE_wen     = de_wen_q;
    assign DE_is_load = de_is_load_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed tests for id_stage, with hand-computed expected values.
// Inputs change 1 time unit after the rising edge. Combinational outputs are
// checked 1 unit later, and D/E outputs are checked 1 unit after the next edge.
module tb_id_stage;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] D_instruc, D_PC, F_PC;
    logic [4:0]  E_waddr;
    logic        E_wen, E_is_load;
    logic [4:0]  M_waddr;
    logic        M_wen, M_is_load;
    logic [31:0] M_wdata;
    logic        W_we;
    logic [4:0]  W_waddr;
    logic [31:0] W_wdata;
    logic [31:0] F_NPC;
    logic        stall;
    logic [31:0] DE_instruc, DE_PC, DE_rs_val, DE_rt_val, DE_imm32;
    logic [4:0]  DE_waddr;
    logic        DE_wen, DE_is_load;

    int checks = 0;
    int errors = 0;

`ifdef ID_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    id_stage #(.RESET_PC(32'h00003000)) dut (
        .clk(clk), .reset(reset),
        .D_instruc(D_instruc), .D_PC(D_PC), .F_PC(F_PC),
        .E_waddr(E_waddr), .E_wen(E_wen), .E_is_load(E_is_load),
        .M_waddr(M_waddr), .M_wen(M_wen), .M_is_load(M_is_load), .M_wdata(M_wdata),
        .W_we(W_we), .W_waddr(W_waddr), .W_wdata(W_wdata),
        .F_NPC(F_NPC), .stall(stall),
        .DE_instruc(DE_instruc), .DE_PC(DE_PC), .DE_rs_val(DE_rs_val),
        .DE_rt_val(DE_rt_val), .DE_imm32(DE_imm32), .DE_waddr(DE_waddr),
        .DE_wen(DE_wen), .DE_is_load(DE_is_load)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'd0, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_pipe;
        E_waddr = 5'd0; E_wen = 1'b0; E_is_load = 1'b0;
        M_waddr = 5'd0; M_wen = 1'b0; M_is_load = 1'b0; M_wdata = 32'd0;
        W_we = 1'b0; W_waddr = 5'd0; W_wdata = 32'd0;
    endtask

    task automatic wr_reg(input logic [4:0] a, input logic [31:0] v);
        D_instruc = 32'd0;
        W_we = 1'b1; W_waddr = a; W_wdata = v;
        tick();
        W_we = 1'b0; W_waddr = 5'd0; W_wdata = 32'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        D_instruc = rtype(5'd1, 5'd2, 5'd3, 6'h21);
        D_PC = 32'h3000; F_PC = 32'h3004;
        idle_pipe();
        tick();
        tick();
        reset = 1'b0;
        D_instruc = 32'd0;
        #1;
        checks++; if (DE_instruc !== 32'd0) begin errors++; $display("FAIL reset_instruc: got %h want %h", DE_instruc, 32'd0); end
        checks++; if (DE_PC !== 32'h3000) begin errors++; $display("FAIL reset_pc: got %h want %h", DE_PC, 32'h3000); end
        checks++; if (DE_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %b want 0", DE_wen); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        for (int i = 1; i < 32; i++) begin
            D_instruc = rtype(i[4:0], i[4:0], 5'd1, 6'h21);
            tick();
            checks++;
            if (DE_rs_val !== 32'd0 || DE_rt_val !== 32'd0) begin
                errors++; $display("FAIL reset_reg%0d: got %h/%h want 0", i, DE_rs_val, DE_rt_val);
            end
        end
        D_instruc = 32'd0;
    endtask

    task automatic test_r0_write;
        wr_reg(5'd0, 32'hFFFF_FFFF);
        W_we = 1'b1; W_waddr = 5'd0; W_wdata = 32'hFFFF_FFFF;
        D_instruc = rtype(5'd0, 5'd0, 5'd5, 6'h21);
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL r0_stall: got %b want 0", stall); end
        tick();
        checks++; if (DE_rs_val !== 32'd0) begin errors++; $display("FAIL r0_rs: got %h want 0", DE_rs_val); end
        checks++; if (DE_rt_val !== 32'd0) begin errors++; $display("FAIL r0_rt: got %h want 0", DE_rt_val); end
        idle_pipe();
    endtask

    task automatic test_beq;
        wr_reg(5'd1, 32'd5);
        wr_reg(5'd2, 32'd5);
        D_instruc = itype(6'h04, 5'd1, 5'd2, 16'd3);
        D_PC = 32'h3010; F_PC = 32'h3014;
        #1;
        checks++; if (F_NPC !== 32'h3020) begin errors++; $display("FAIL beq_taken: got %h want %h", F_NPC, 32'h3020); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL beq_stall: got %b want 0", stall); end
        tick();
        checks++; if (DE_imm32 !== 32'd3 || DE_wen !== 1'b0) begin errors++; $display("FAIL beq_de: got imm %h wen %b want 3/0", DE_imm32, DE_wen); end
        wr_reg(5'd2, 32'd6);
        D_instruc = itype(6'h04, 5'd1, 5'd2, 16'd3);
        #1;
        checks++; if (F_NPC !== 32'h3018) begin errors++; $display("FAIL beq_nottaken: got %h want %h", F_NPC, 32'h3018); end
        tick();
        checks++; if (DE_rs_val !== 32'd5 || DE_rt_val !== 32'd6) begin errors++; $display("FAIL beq_ops: got %h/%h want 5/6", DE_rs_val, DE_rt_val); end
    endtask

    task automatic test_jal;
        D_instruc = {6'h03, 26'h0000C10};
        D_PC = 32'h3004; F_PC = 32'h3008;
        #1;
        checks++; if (F_NPC !== 32'h3040) begin errors++; $display("FAIL jal_npc: got %h want %h", F_NPC, 32'h3040); end
        tick();
        checks++; if (DE_imm32 !== 32'h300C) begin errors++; $display("FAIL jal_link: got %h want %h", DE_imm32, 32'h300C); end
        checks++; if (DE_waddr !== 5'd31 || DE_wen !== 1'b1) begin errors++; $display("FAIL jal_dest: got %0d/%b want 31/1", DE_waddr, DE_wen); end
        checks++; if (DE_PC !== 32'h3004) begin errors++; $display("FAIL jal_pc: got %h want %h", DE_PC, 32'h3004); end
    endtask

    task automatic test_load_beq;
        logic [31:0] beq_w;
        beq_w = itype(6'h04, 5'd3, 5'd0, 16'd1);
        D_instruc = beq_w; D_PC = 32'h3020; F_PC = 32'h3024;
        E_waddr = 5'd3; E_wen = 1'b1; E_is_load = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_stall_e: got %b want 1", stall); end
        tick();
        checks++; if (DE_instruc !== 32'd0 || DE_PC !== 32'h3000) begin errors++; $display("FAIL ld_bubble1: got %h/%h want 0/3000", DE_instruc, DE_PC); end
        E_waddr = 5'd0; E_wen = 1'b0; E_is_load = 1'b0;
        M_waddr = 5'd3; M_wen = 1'b1; M_is_load = 1'b1; M_wdata = 32'hDEAD;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL ld_stall_m: got %b want 1", stall); end
        tick();
        checks++; if (DE_instruc !== 32'd0) begin errors++; $display("FAIL ld_bubble2: got %h want 0", DE_instruc); end
        M_waddr = 5'd0; M_wen = 1'b0; M_is_load = 1'b0; M_wdata = 32'd0;
        W_we = 1'b1; W_waddr = 5'd3; W_wdata = 32'd7;
        #1;
        checks++; if (stall !== !BYP) begin errors++; $display("FAIL ld_stall_w: got %b want %b", stall, !BYP); end
        tick();
        checks++; if (DE_instruc !== (BYP ? beq_w : 32'd0)) begin errors++; $display("FAIL ld_de_w: got %h want %h", DE_instruc, BYP ? beq_w : 32'd0); end
        W_we = 1'b0; W_waddr = 5'd0; W_wdata = 32'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ld_resolve_stall: got %b want 0", stall); end
        checks++; if (F_NPC !== 32'h3028) begin errors++; $display("FAIL ld_resolve_npc: got %h want %h", F_NPC, 32'h3028); end
        tick();
        checks++; if (DE_instruc !== beq_w || DE_rs_val !== 32'd7) begin errors++; $display("FAIL ld_de: got %h/%h want %h/7", DE_instruc, DE_rs_val, beq_w); end
    endtask

    task automatic test_alu_beq;
        wr_reg(5'd8, 32'd9);
        D_instruc = itype(6'h04, 5'd8, 5'd0, 16'd2);
        D_PC = 32'h3040; F_PC = 32'h3044;
        E_waddr = 5'd8; E_wen = 1'b1; E_is_load = 1'b0;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL alu_stall_e: got %b want 1", stall); end
        tick();
        checks++; if (DE_instruc !== 32'd0) begin errors++; $display("FAIL alu_bubble: got %h want 0", DE_instruc); end
        E_waddr = 5'd0; E_wen = 1'b0;
        M_waddr = 5'd8; M_wen = 1'b1; M_is_load = 1'b0; M_wdata = 32'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL alu_stall_m: got %b want 0", stall); end
        checks++; if (F_NPC !== 32'h304C) begin errors++; $display("FAIL alu_fwd_npc: got %h want %h", F_NPC, 32'h304C); end
        tick();
        idle_pipe();
    endtask

    task automatic test_forward;
        logic [31:0] add_w;
        add_w = rtype(5'd4, 5'd0, 5'd6, 6'h21);
        M_waddr = 5'd4; M_wen = 1'b1; M_is_load = 1'b0; M_wdata = 32'h1234;
        D_instruc = add_w; D_PC = 32'h3060; F_PC = 32'h3064;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL fwd_stall: got %b want 0", stall); end
        tick();
        checks++; if (DE_rs_val !== 32'h1234) begin errors++; $display("FAIL fwd_rs: got %h want %h", DE_rs_val, 32'h1234); end
        checks++; if (DE_waddr !== 5'd6 || DE_wen !== 1'b1) begin errors++; $display("FAIL fwd_dest: got %0d/%b want 6/1", DE_waddr, DE_wen); end
        idle_pipe();
        W_we = 1'b1; W_waddr = 5'd4; W_wdata = 32'h55;
        #1;
        checks++; if (stall !== !BYP) begin errors++; $display("FAIL wdep_stall: got %b want %b", stall, !BYP); end
        tick();
        checks++; if (DE_rs_val !== (BYP ? 32'h55 : 32'd0)) begin errors++; $display("FAIL wdep_de: got %h want %h", DE_rs_val, BYP ? 32'h55 : 32'd0); end
        W_we = 1'b0; W_waddr = 5'd0; W_wdata = 32'd0;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL wdep_after: got %b want 0", stall); end
        tick();
        checks++; if (DE_rs_val !== 32'h55 || DE_instruc !== add_w) begin errors++; $display("FAIL wdep_value: got %h/%h want 55/%h", DE_rs_val, DE_instruc, add_w); end
    endtask

    task automatic test_jr;
        wr_reg(5'd9, 32'h3100);
        D_instruc = rtype(5'd9, 5'd0, 5'd0, 6'h08); D_PC = 32'h3080; F_PC = 32'h3084;
        #1;
        checks++; if (F_NPC !== 32'h3100 || stall !== 1'b0) begin errors++; $display("FAIL jr_npc: got %h/%b want 3100/0", F_NPC, stall); end
        E_waddr = 5'd9; E_wen = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL jr_stall: got %b want 1", stall); end
        tick();
        idle_pipe();
    endtask

    task automatic test_decode;
        D_instruc = itype(6'h0F, 5'd0, 5'd10, 16'h1234); tick();
        checks++; if (DE_imm32 !== 32'h12340000 || DE_waddr !== 5'd10 || DE_wen !== 1'b1) begin errors++; $display("FAIL lui: got %h/%0d/%b want 12340000/10/1", DE_imm32, DE_waddr, DE_wen); end
        D_instruc = itype(6'h0D, 5'd0, 5'd11, 16'h8001); tick();
        checks++; if (DE_imm32 !== 32'h00008001 || DE_waddr !== 5'd11) begin errors++; $display("FAIL ori: got %h/%0d want 00008001/11", DE_imm32, DE_waddr); end
        D_instruc = itype(6'h23, 5'd0, 5'd12, 16'hFFFC); tick();
        checks++; if (DE_imm32 !== 32'hFFFFFFFC || DE_waddr !== 5'd12 || DE_is_load !== 1'b1) begin errors++; $display("FAIL lw: got %h/%0d/%b want FFFFFFFC/12/1", DE_imm32, DE_waddr, DE_is_load); end
        D_instruc = itype(6'h2B, 5'd0, 5'd12, 16'h0008); tick();
        checks++; if (DE_wen !== 1'b0 || DE_waddr !== 5'd0 || DE_imm32 !== 32'd8) begin errors++; $display("FAIL sw: got %b/%0d/%h want 0/0/8", DE_wen, DE_waddr, DE_imm32); end
        D_instruc = rtype(5'd1, 5'd2, 5'd13, 6'h23); tick();
        checks++; if (DE_waddr !== 5'd13 || DE_rs_val !== 32'd5 || DE_rt_val !== 32'd6) begin errors++; $display("FAIL subu: got %0d/%h/%h want 13/5/6", DE_waddr, DE_rs_val, DE_rt_val); end
        D_instruc = itype(6'h08, 5'd0, 5'd14, 16'd5); tick();
        checks++; if (DE_wen !== 1'b0) begin errors++; $display("FAIL unsupported: got wen %b want 0", DE_wen); end
        D_instruc = rtype(5'd1, 5'd2, 5'd0, 6'h21); tick();
        checks++; if (DE_wen !== 1'b0) begin errors++; $display("FAIL addu_rd0: got wen %b want 0", DE_wen); end
    endtask

    task automatic test_reset_mid_stall;
        D_instruc = itype(6'h04, 5'd3, 5'd0, 16'd4); D_PC = 32'h3020; F_PC = 32'h3024;
        E_waddr = 5'd3; E_wen = 1'b1; E_is_load = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_stall: got %b want 1", stall); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (DE_instruc !== 32'd0 || DE_PC !== 32'h3000) begin errors++; $display("FAIL rst_mid_de: got %h/%h want 0/3000", DE_instruc, DE_PC); end
        idle_pipe();
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_after: got %b want 0", stall); end
        checks++; if (F_NPC !== 32'h3034) begin errors++; $display("FAIL rst_mid_npc: got %h want %h", F_NPC, 32'h3034); end
    endtask

    initial begin
        test_reset();
        test_r0_write();
        test_beq();
        test_jal();
        test_load_beq();
        test_alu_beq();
        test_forward();
        test_jr();
        test_decode();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/id_stage.md
# id_stage

Decode stage of the five-stage MIPS pipeline, fed directly by the fetch stage (instruction word and PC held in the F/D register) and feeding the execute stage through its own D/E pipeline register. It decodes the supported subset, owns the 32×32 general register file, and resolves branches and jumps in D, returning the next fetch PC. It detects read-after-write hazards, forwards data from the M stage, and raises `stall` to freeze fetch while inserting a bubble into D/E.

## Interface

Parameters:
- `RESET_PC`, 32'h00003000: value placed on `DE_PC` when a bubble is inserted; the pipeline uses it as its reset PC.

Ports:
- `clk` in 1: rising-edge clock.
- `reset` in 1: synchronous, active-high.
- `D_instruc` in 32: instruction in D, from the fetch F/D register.
- `D_PC` in 32: PC of `D_instruc`.
- `F_PC` in 32: PC currently being fetched, which is the delay-slot address.
- `E_waddr` in 5, `E_wen` in 1, `E_is_load` in 1: destination, write enable and load flag of the instruction in E.
- `M_waddr` in 5, `M_wen` in 1, `M_is_load` in 1, `M_wdata` in 32: the instruction in M and its ALU result.
- `W_we` in 1, `W_waddr` in 5, `W_wdata` in 32: register-file write port.
- `F_NPC` out 32: next fetch PC.
- `stall` out 1: freezes fetch and the F/D register.
- `DE_instruc`, `DE_PC`, `DE_rs_val`, `DE_rt_val`, `DE_imm32` out 32: D/E register contents.
- `DE_waddr` out 5: destination register of the instruction in D/E.
- `DE_wen` out 1, `DE_is_load` out 1: write enable and load flag of the instruction in D/E.

## Operation

Supported instructions: `addu`, `subu`, `ori`, `lui`, `lw`, `sw`, `beq`, `jal`, `jr`, `nop`. Any other opcode or funct decodes as `nop` (`DE_wen`=0).

Destination register (`waddr`):
- `addu`, `subu`: rd.
- `ori`, `lui`, `lw`: rt.
- `jal`: 31.
- `waddr`=0 forces `wen`=0.

`imm32`:
- `ori`: zero-extended imm16.
- `lw`, `sw`, `beq`: sign-extended imm16.
- `lui`: {imm16, 16'b0}.
- `jal`: `D_PC`+8, the link value.

Register file:
- Write at the rising edge when `W_we` && `W_waddr`≠0. Register 0 always reads 0.
- Two combinational read ports, indexed by rs and rt.

Operand value (`rs_val`, `rt_val`), in priority order:
1. 0 if the address is 0.
2. `M_wdata` if `M_wen` && !`M_is_load` && `M_waddr` equals the address.
3. Otherwise the register-file read (see Configuration).

Use classes:
- Early use: rs of `beq` and `jr`, rt of `beq`.
- Late use: rs of `addu`, `subu`, `ori`, `lw`, `sw`, and rt of `addu`, `subu`, `sw`.

`stall`=1 when any of the following holds (address ≠0 in every case):
- An early-use register matches `E_waddr` with `E_wen`.
- An early-use register matches `M_waddr` with `M_wen` && `M_is_load`.
- Any used register matches `E_waddr` with `E_wen` && `E_is_load`.

`F_NPC`, with branch delay slot (the instruction at `F_PC` always executes):
- `beq` with `rs_val`==`rt_val` and !`stall`: `D_PC`+4+(sext(imm16)<<2).
- `jal`: {`D_PC`[31:28], instr[25:0], 2'b00}.
- `jr` with !`stall`: `rs_val`.
- Otherwise: `F_PC`+4.
- While `stall`=1 the value is don't-care, because fetch is frozen.

D/E register, updated every rising edge:
- `reset` or `stall`: load a bubble. All fields become 0 except `DE_PC`=`RESET_PC`.
- Otherwise: load the decoded fields.

## Timing

- Reset is synchronous. After the reset edge all D/E outputs are 0 (`DE_PC`=`RESET_PC`) and all 32 registers read 0.
- `stall`, `F_NPC`, `rs_val` and `rt_val` are combinational from inputs in the same cycle.
- D/E latency is one cycle. A stalled instruction stays in D (fetch is frozen) and re-evaluates every cycle, with one bubble inserted per stall cycle.
- A load in E followed by a dependent `beq` gives 2 stall cycles: first for E-load, then for M-load.
- An ALU result in E followed by a dependent `beq` gives 1 stall cycle, then the M forward applies.
- A same-edge write to register 0 is discarded.
- Reset mid-stall clears D/E. `stall` then follows the cleared pipeline inputs.

## Configuration

`ID_WB_BYPASS_EN`:
- Defined: each read port returns `W_wdata` when `W_we` && `W_waddr` equals the read address (≠0) in the same cycle, as a write-through.
- Undefined: reads return the stored value, and the stall condition gains an extra term: any used register equals `W_waddr` with `W_we`. This costs one stall cycle per W-stage dependency.

## Test plan

- Reset, then read registers 1..31 -> all 0. `DE_instruc`=0. `DE_PC`=32'h3000. `stall`=0.
- `W_we`=1, `W_waddr`=0, `W_wdata`=32'hFFFF_FFFF, then `addu` reading $0 -> `DE_rs_val`=0.
- `beq $1,$2,+3` at `D_PC`=32'h3010 with $1=$2=5 -> `F_NPC`=32'h3020. With $2=6 -> `F_NPC`=`F_PC`+4.
- `jal` with instr[25:0]=26'h0000C10 at `D_PC`=32'h3004 -> `F_NPC`=32'h3040, `DE_imm32`=32'h300C, `DE_waddr`=31.
- `lw $3` in E, `beq $3,$0` in D -> `stall`=1 for 2 cycles, 2 bubbles in D/E, then branch resolves using the register value.
- `M_wen`=1, `M_waddr`=4, `M_wdata`=32'h1234, `addu` in D reading $4 -> `DE_rs_val`=32'h1234, no stall. With the bypass macro undefined and $4 being written by W -> 1 stall cycle.
